qr_skew_sequencer: RTL and testbench
====================================

// Module: qr_skew_sequencer
// PURPOSE
//  Parametrised input-skew and cell-sequencing front end for a ROWS x COLS triangular Givens-rotation (QR) systolic array.
//  Accepts one matrix row per handshake beat, emits column-skewed data, and drives per-cell enable/init strobes on the wavefront.
//  Supports back-to-back frames with sof/eof framing, bubbles, abort and a done pulse. Cell arithmetic is outside this block.
// PARAMETERS
//  ROWS  2   triangular depth (boundary cells); 1 <= ROWS <= COLS
//  COLS  4   matrix columns (cells per top row)
//  DW    32  data width per element
// PORTS
//  clk        in   1          clock, all logic on rising edge
//  rst        in   1          synchronous reset, active-high
//  abort      in   1          synchronous flush of in-flight frame
//  in_valid   in   1          row beat valid
//  in_ready   out  1          block can accept a beat
//  in_sof     in   1          beat is first row of a matrix
//  in_eof     in   1          beat is last row of a matrix
//  in_data    in   COLS*DW    row elements, column j at [j*DW +: DW]
//  x_skew     out  COLS*DW    skewed column data to top array row
//  cell_en    out  ROWS*COLS  cell (i,j) data strobe, bit i*COLS+j
//  cell_init  out  ROWS*COLS  cell (i,j) first-row-of-frame strobe, same indexing
//  busy       out  1          state != IDLE
//  done       out  1          one-cycle pulse, frame fully drained
//  err        out  1          one-cycle pulse, framing violation
// BEHAVIOUR
//  Reset/abort: state IDLE; x_skew, cell_en, cell_init, done, err, busy = 0; all shift stages cleared; in_ready=1 next cycle.
//  Accept = in_valid && in_ready at edge t. Bits with j<i of cell_en/cell_init are constant 0.
//  Data skew: column j of accepted beat appears on x_skew[j] exactly at cycle t+1+j; held 0 when no beat in that slot.
//  Strobes: cell_en(i,j) high exactly in cycle t+1+i+j for each accepted beat; cell_init(i,j) same cycle, only if beat was first of frame.
//  Bubbles (no accept in a cycle) propagate as 0 through every stage; no compaction.
//  FSM IDLE: in_ready=1. Accept with sof -> STREAM (init set); with sof&eof -> DRAIN.
//    Accept without sof -> beat discarded (no strobes), err pulse, stay IDLE.
//  FSM STREAM: in_ready=1. Accept with eof -> DRAIN. Accept with sof -> frame restarts: beat tagged init, err pulse.
//  FSM DRAIN: in_ready=0; counter loads ROWS+COLS-2 on entry, decrements each cycle.
//    At 0: done=1 in cycle t_last+ROWS+COLS (one after last strobe of cell (ROWS-1,COLS-1)), -> IDLE.
//  ROWS=COLS=1: DRAIN count 0; done in cycle t_last+2.
//  abort has priority over any accept in same cycle; no done after abort. rst has priority over abort.
//  Counter width $clog2(ROWS+COLS)+1; all outputs registered; no combinational in->out paths except none (in_ready from state reg).
// TESTING
//  1. Defaults, one frame of 2 rows (sof row0, eof row1) at t=0,1 -> cell_en(0,0) at 1,2; cell_en(1,3) at 5,6; init only at 1 / 5; done at 7.
//  2. Row values col j = 0x10+j at t=0 -> x_skew[j] = 0x10+j exactly at cycle 1+j, 0 elsewhere.
//  3. Bubble: beats at t=0 and t=2 (valid low at 1) -> cell_en(0,1) at 2 and 4, low at 3.
//  4. Beat without sof in IDLE -> err pulse, no cell_en/x_skew activity, state IDLE.
//  5. abort at cycle 3 mid-frame -> all strobes 0 from cycle 4, in_ready=1, no done.
//  6. ROWS=3,COLS=5: sof&eof single beat at t=0 -> cell_en(2,4) at 7, done at 8, in_ready low cycles 1..8.

Source files
------------

// File: rtl/qr_skew_sequencer.sv
// qr_skew_sequencer: input skew and cell sequencing front end for a
// ROWS x COLS triangular Givens-rotation systolic array.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   abort               synchronous flush of the in-flight frame
//   in_valid/in_ready   row beat handshake (in_ready is a flop)
//   in_sof/in_eof       first/last row of a matrix
//   in_data             row elements, column j at [j*DW +: DW]
//   x_skew              column j delayed by 1+j cycles
//   cell_en/cell_init   per-cell strobes, bit i*COLS+j, delayed 1+i+j cycles
//   busy, done, err     status: not idle, frame drained pulse, framing error pulse
module qr_skew_sequencer #(
  parameter int unsigned ROWS = 2,
  parameter int unsigned COLS = 4,
  parameter int unsigned DW   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sof,
  input  logic                 in_eof,
  input  logic [COLS*DW-1:0]   in_data,
  output logic [COLS*DW-1:0]   x_skew,
  output logic [ROWS*COLS-1:0] cell_en,
  output logic [ROWS*COLS-1:0] cell_init,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  // Strobe pipeline depth: stage s feeds every cell on anti-diagonal i+j == s.
  localparam int unsigned NS = ROWS + COLS - 1;
  localparam int unsigned CW = $clog2(ROWS + COLS) + 1;
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(ROWS + COLS - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          accept_c;
  logic          keep_c;
  logic          first_c;
  logic [NS-1:0] en_q;
  logic [NS-1:0] init_q;

  assign accept_c = in_valid && ready_q;

  // Next state, drain counter and beat classification.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    keep_c  = 1'b0;
    first_c = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_c) begin
            if (in_sof) begin
              keep_c  = 1'b1;
              first_c = 1'b1;
              if (in_eof) begin
                state_d = S_DRAIN;
                cnt_d   = DRAIN_LOAD;
              end else begin
                state_d = S_STREAM;
              end
            end else begin
              // Mid-frame beat with no open frame is dropped.
              err_d = 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (accept_c) begin
            keep_c  = 1'b1;
            // A repeated sof restarts the frame: tag it init and flag it.
            first_c = in_sof;
            err_d   = in_sof;
            if (in_eof) begin
              state_d = S_DRAIN;
              cnt_d   = DRAIN_LOAD;
            end
          end
        end
        S_DRAIN: begin
          // Stay in DRAIN through the done cycle so in_ready stays low.
          if (done_q) begin
            state_d = S_IDLE;
          end else if (cnt_q == '0) begin
            done_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    ready_d = (state_d != S_DRAIN);
    busy_d  = (state_d != S_IDLE);
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Wavefront strobe pipeline; bubbles shift through as zeros.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      en_q   <= '0;
      init_q <= '0;
    end else begin
      en_q[0]   <= keep_c;
      init_q[0] <= first_c;
      for (int s = 1; s < NS; s++) begin
        en_q[s]   <= en_q[s-1];
        init_q[s] <= init_q[s-1];
      end
    end
  end

  // Per-column data delay line of depth 1+j.
  for (genvar j = 0; j < COLS; j++) begin : g_col
    logic [DW-1:0] sr_q [j+1];

    always_ff @(posedge clk) begin
      if (rst || abort) begin
        for (int k = 0; k <= j; k++) begin
          sr_q[k] <= '0;
        end
      end else begin
        sr_q[0] <= keep_c ? in_data[j*DW +: DW] : '0;
        for (int k = 1; k <= j; k++) begin
          sr_q[k] <= sr_q[k-1];
        end
      end
    end

    assign x_skew[j*DW +: DW] = sr_q[j];
  end

  // Cell (i,j) takes anti-diagonal stage i+j; cells below the diagonal are tied off.
  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_cell
      if (j >= i) begin : g_live
        assign cell_en[i*COLS+j]   = en_q[i+j];
        assign cell_init[i*COLS+j] = init_q[i+j];
      end else begin : g_tie
        assign cell_en[i*COLS+j]   = 1'b0;
        assign cell_init[i*COLS+j] = 1'b0;
      end
    end
  end

  assign in_ready = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_qr_skew_sequencer.sv
// Directed bench for qr_skew_sequencer: a per-cycle vector table on the
// default 2x4 instance, then hand sequences on 3x5 and 1x1 instances.
module tb_qr_skew_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Default 2x4, DW=32 instance
  logic         a_abort, a_valid, a_sof, a_eof, a_ready, a_busy, a_done, a_err;
  logic [127:0] a_data, a_x;
  logic [7:0]   a_en, a_init;

  // 3x5, DW=8 instance
  logic         b_abort, b_valid, b_sof, b_eof, b_ready, b_busy, b_done, b_err;
  logic [39:0]  b_data, b_x;
  logic [14:0]  b_en, b_init;

  // 1x1, DW=8 instance
  logic         o_abort, o_valid, o_sof, o_eof, o_ready, o_busy, o_done, o_err;
  logic [7:0]   o_data, o_x;
  logic [0:0]   o_en, o_init;

  qr_skew_sequencer #(.ROWS(2), .COLS(4), .DW(32)) u_dut (
    .clk(clk), .rst(rst), .abort(a_abort), .in_valid(a_valid), .in_ready(a_ready),
    .in_sof(a_sof), .in_eof(a_eof), .in_data(a_data), .x_skew(a_x),
    .cell_en(a_en), .cell_init(a_init), .busy(a_busy), .done(a_done), .err(a_err)
  );

  qr_skew_sequencer #(.ROWS(3), .COLS(5), .DW(8)) u_big (
    .clk(clk), .rst(rst), .abort(b_abort), .in_valid(b_valid), .in_ready(b_ready),
    .in_sof(b_sof), .in_eof(b_eof), .in_data(b_data), .x_skew(b_x),
    .cell_en(b_en), .cell_init(b_init), .busy(b_busy), .done(b_done), .err(b_err)
  );

  qr_skew_sequencer #(.ROWS(1), .COLS(1), .DW(8)) u_one (
    .clk(clk), .rst(rst), .abort(o_abort), .in_valid(o_valid), .in_ready(o_ready),
    .in_sof(o_sof), .in_eof(o_eof), .in_data(o_data), .x_skew(o_x),
    .cell_en(o_en), .cell_init(o_init), .busy(o_busy), .done(o_done), .err(o_err)
  );

  // One row per cycle: inputs driven in that cycle, outputs seen in that cycle.
  typedef struct {
    logic [3:0]   in;   // {valid, sof, eof, abort}
    logic [127:0] data;
    logic [3:0]   fl;   // {in_ready, busy, done, err}
    logic [7:0]   en;
    logic [7:0]   init;
    logic [127:0] x;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [127:0] x4(input logic [31:0] c3, input logic [31:0] c2,
                                      input logic [31:0] c1, input logic [31:0] c0);
    return {c3, c2, c1, c0};
  endfunction

  task automatic add(input logic [3:0] in, input logic [127:0] data, input logic [3:0] fl,
                     input logic [7:0] en, input logic [7:0] init, input logic [127:0] x);
    vec_t v;
    v.in = in; v.data = data; v.fl = fl; v.en = en; v.init = init; v.x = x;
    vq.push_back(v);
  endtask

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected 3x5 strobe mask for a single beat accepted at cycle 0.
  function automatic logic [14:0] big_mask(input int c);
    case (c)
      1:       return 15'h0001;
      2:       return 15'h0002;
      3:       return 15'h0044;
      4:       return 15'h0088;
      5:       return 15'h1110;
      6:       return 15'h2200;
      7:       return 15'h4000;
      default: return 15'h0000;
    endcase
  endfunction

  localparam logic [3:0] I0   = 4'b0000;
  localparam logic [3:0] ISOF = 4'b1100;
  localparam logic [3:0] IEOF = 4'b1010;
  localparam logic [3:0] IMID = 4'b1000;
  localparam logic [3:0] ISE  = 4'b1110;
  localparam logic [3:0] IABT = 4'b1011;

  initial begin
    rst = 1'b1;
    a_abort = 1'b0; a_valid = 1'b0; a_sof = 1'b0; a_eof = 1'b0; a_data = '0;
    b_abort = 1'b0; b_valid = 1'b0; b_sof = 1'b0; b_eof = 1'b0; b_data = '0;
    o_abort = 1'b0; o_valid = 1'b0; o_sof = 1'b0; o_eof = 1'b0; o_data = '0;

    // Two-row frame with column-tagged data
    add(ISOF, x4('h13, 'h12, 'h11, 'h10), 4'b1000, 8'h00, 8'h00, '0);
    add(IEOF, x4('h23, 'h22, 'h21, 'h20), 4'b1100, 8'h01, 8'h01, x4(0, 0, 0, 'h10));
    add(I0,   '0, 4'b0100, 8'h03, 8'h02, x4(0, 0, 'h11, 'h20));
    add(I0,   '0, 4'b0100, 8'h26, 8'h24, x4(0, 'h12, 'h21, 0));
    add(I0,   '0, 4'b0100, 8'h6C, 8'h48, x4('h13, 'h22, 0, 0));
    add(I0,   '0, 4'b0100, 8'hC8, 8'h80, x4('h23, 0, 0, 0));
    add(I0,   '0, 4'b0100, 8'h80, 8'h00, '0);
    add(I0,   '0, 4'b0110, 8'h00, 8'h00, '0);
    // Bubble between two beats
    add(ISOF, x4('h33, 'h32, 'h31, 'h30), 4'b1000, 8'h00, 8'h00, '0);
    add(I0,   '0, 4'b1100, 8'h01, 8'h01, x4(0, 0, 0, 'h30));
    add(IEOF, x4('h43, 'h42, 'h41, 'h40), 4'b1100, 8'h02, 8'h02, x4(0, 0, 'h31, 0));
    add(I0,   '0, 4'b0100, 8'h25, 8'h24, x4(0, 'h32, 0, 'h40));
    add(I0,   '0, 4'b0100, 8'h4A, 8'h48, x4('h33, 0, 'h41, 0));
    add(I0,   '0, 4'b0100, 8'hA4, 8'h80, x4(0, 'h42, 0, 0));
    add(I0,   '0, 4'b0100, 8'h48, 8'h00, x4('h43, 0, 0, 0));
    add(I0,   '0, 4'b0100, 8'h80, 8'h00, '0);
    add(I0,   '0, 4'b0110, 8'h00, 8'h00, '0);
    // Beat without sof while idle
    add(IMID, x4('h53, 'h52, 'h51, 'h50), 4'b1000, 8'h00, 8'h00, '0);
    add(I0,   '0, 4'b1001, 8'h00, 8'h00, '0);
    // Abort mid-frame, colliding with an eof beat
    add(ISOF, x4('h63, 'h62, 'h61, 'h60), 4'b1000, 8'h00, 8'h00, '0);
    add(IMID, x4('h73, 'h72, 'h71, 'h70), 4'b1100, 8'h01, 8'h01, x4(0, 0, 0, 'h60));
    add(IMID, x4('h83, 'h82, 'h81, 'h80), 4'b1100, 8'h03, 8'h02, x4(0, 0, 'h61, 'h70));
    add(IABT, x4('h93, 'h92, 'h91, 'h90), 4'b1100, 8'h27, 8'h24, x4(0, 'h62, 'h71, 'h80));
    for (int k = 0; k < 7; k++) add(I0, '0, 4'b1000, 8'h00, 8'h00, '0);
    // Repeated sof inside a frame, second beat also eof
    add(ISOF, x4('hB3, 'hB2, 'hB1, 'hB0), 4'b1000, 8'h00, 8'h00, '0);
    add(ISE,  x4('hC3, 'hC2, 'hC1, 'hC0), 4'b1100, 8'h01, 8'h01, x4(0, 0, 0, 'hB0));
    add(I0,   '0, 4'b0101, 8'h03, 8'h03, x4(0, 0, 'hB1, 'hC0));
    add(I0,   '0, 4'b0100, 8'h26, 8'h26, x4(0, 'hB2, 'hC1, 0));
    add(I0,   '0, 4'b0100, 8'h6C, 8'h6C, x4('hB3, 'hC2, 0, 0));
    add(I0,   '0, 4'b0100, 8'hC8, 8'hC8, x4('hC3, 0, 0, 0));
    add(I0,   '0, 4'b0100, 8'h80, 8'h80, '0);
    add(I0,   '0, 4'b0110, 8'h00, 8'h00, '0);
    add(I0,   '0, 4'b1000, 8'h00, 8'h00, '0);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int r = 0; r < vq.size(); r++) begin
      {a_valid, a_sof, a_eof, a_abort} = vq[r].in;
      a_data = vq[r].data;
      @(negedge clk);
      check($sformatf("r%0d_ready", r), 128'(a_ready), 128'(vq[r].fl[3]));
      check($sformatf("r%0d_busy", r),  128'(a_busy),  128'(vq[r].fl[2]));
      check($sformatf("r%0d_done", r),  128'(a_done),  128'(vq[r].fl[1]));
      check($sformatf("r%0d_err", r),   128'(a_err),   128'(vq[r].fl[0]));
      check($sformatf("r%0d_en", r),    128'(a_en),    128'(vq[r].en));
      check($sformatf("r%0d_init", r),  128'(a_init),  128'(vq[r].init));
      check($sformatf("r%0d_x", r),     a_x,           vq[r].x);
      @(posedge clk);
      #1;
    end
    {a_valid, a_sof, a_eof, a_abort} = I0;
    a_data = '0;

    // Single sof&eof beat on the 3x5 and 1x1 instances
    b_data = {8'h44, 8'h33, 8'h22, 8'h11, 8'h0F};
    o_data = 8'hA5;
    for (int c = 0; c <= 10; c++) begin
      logic [39:0] bx;
      b_valid = (c == 0); b_sof = (c == 0); b_eof = (c == 0);
      o_valid = (c == 0); o_sof = (c == 0); o_eof = (c == 0);
      @(negedge clk);
      bx = '0;
      if (c >= 1 && c <= 5) bx[(c-1)*8 +: 8] = b_data[(c-1)*8 +: 8];
      check($sformatf("big_c%0d_ready", c), 128'(b_ready), 128'(!(c >= 1 && c <= 8)));
      check($sformatf("big_c%0d_busy", c),  128'(b_busy),  128'(c >= 1 && c <= 8));
      check($sformatf("big_c%0d_done", c),  128'(b_done),  128'(c == 8));
      check($sformatf("big_c%0d_err", c),   128'(b_err),   128'(0));
      check($sformatf("big_c%0d_en", c),    128'(b_en),    128'(big_mask(c)));
      check($sformatf("big_c%0d_init", c),  128'(b_init),  128'(big_mask(c)));
      check($sformatf("big_c%0d_x", c),     128'(b_x),     128'(bx));
      check($sformatf("one_c%0d_ready", c), 128'(o_ready), 128'(!(c >= 1 && c <= 2)));
      check($sformatf("one_c%0d_busy", c),  128'(o_busy),  128'(c >= 1 && c <= 2));
      check($sformatf("one_c%0d_done", c),  128'(o_done),  128'(c == 2));
      check($sformatf("one_c%0d_en", c),    128'(o_en),    128'(c == 1));
      check($sformatf("one_c%0d_init", c),  128'(o_init),  128'(c == 1));
      check($sformatf("one_c%0d_x", c),     128'(o_x),     (c == 1) ? 128'h0A5 : 128'h0);
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
